// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle
//
// Memory-access pipeline stage. It sits between the M-stage control/data
// signals and the writeback stage. Loads and stores go to a variable-latency
// data bus that uses a req/ready handshake. This stage does byte-lane steering
// for stores and sign/zero extension for loads. It raises StallM to the hazard
// unit while an access is in progress.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When defined, a misaligned half/word access is not issued to the bus.
//   Instead it produces a one-cycle MisalignM pulse and a bubble in W.
//   When undefined, the low address bits are ignored and the access goes to
//   the containing aligned halfword or word.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   RegWriteM, ResultSrcM    M-stage register write enable / load select
//   MemWriteM                M-stage store
//   Funct3M                  access size (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   RdM, PCPlus4M            destination register, link value
//   ALU_ResultM              effective address or ALU result
//   WriteDataM               store data
//   mem_req/mem_we           bus request / write select
//   mem_addr                 word-aligned bus address
//   mem_wdata/mem_wstrb      lane-replicated store data / byte strobes
//   mem_ready/mem_rdata      access complete / raw read word
//   StallM                   combinational freeze of F/D/E/M
//   MisalignM                misaligned-access pulse (MISALIGN_TRAP_EN only)
//   RegWriteW..ReadDataW     registered writeback-stage outputs
// -----------------------------------------------------------------------------
module memory_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
`ifdef MISALIGN_TRAP_EN
  output logic        MisalignM,
`endif
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Size code is Funct3[1:0]: 00 byte, 01 half, anything else is a full word.
  // Funct3[2] selects zero extension for loads.

  // Store data is replicated across all lanes so that the strobes alone
  // select the bytes that are written.
  function automatic logic [31:0] store_wdata(input logic [31:0] wd,
                                              input logic [2:0]  f3);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3,
                                             input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Halfword selection uses only addr[1], so a halfword access with addr[0]
  // set reads the containing aligned halfword.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lo);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [7:0]  b;
    logic [15:0] h;
    bsh = rdata >> {lo, 3'b000};
    hsh = rdata >> {lo[1], 4'b0000};
    b   = bsh[7:0];
    h   = hsh[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction
`endif

  logic mem_op;
  logic start;
  logic trap;

  assign mem_op = ResultSrcM | MemWriteM;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and stall. StallM is 1 for an op waiting in IDLE and for every
  // BUSY cycle. It drops in DONE, so the pipeline advances at the end of DONE.
  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    start     = 1'b0;
    trap      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(Funct3M, ALU_ResultM[1:0])) begin
            trap = 1'b1;
          end else begin
            start     = 1'b1;
            StallM    = 1'b1;
            state_nxt = BUSY;
          end
`else
          start     = 1'b1;
          StallM    = 1'b1;
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (mem_ready) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- stage p0: request registers, held stable for the whole BUSY phase ----
  logic        req_we_p0;
  logic [31:0] req_addr_p0;
  logic [31:0] req_wdata_p0;
  logic [3:0]  req_wstrb_p0;
  logic [1:0]  req_lo_p0;
  logic [2:0]  req_f3_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we_p0    <= 1'b0;
      req_addr_p0  <= 32'd0;
      req_wdata_p0 <= 32'd0;
      req_wstrb_p0 <= 4'd0;
      req_lo_p0    <= 2'd0;
      req_f3_p0    <= 3'd0;
    end else if (start) begin
      req_we_p0    <= MemWriteM;
      req_addr_p0  <= {ALU_ResultM[31:2], 2'b00};
      req_wdata_p0 <= store_wdata(WriteDataM, Funct3M);
      req_wstrb_p0 <= MemWriteM ? store_wstrb(Funct3M, ALU_ResultM[1:0]) : 4'b0000;
      req_lo_p0    <= ALU_ResultM[1:0];
      req_f3_p0    <= Funct3M;
    end
  end

  assign mem_req   = (state == BUSY);
  assign mem_we    = req_we_p0;
  assign mem_addr  = req_addr_p0;
  assign mem_wdata = req_wdata_p0;
  assign mem_wstrb = req_wstrb_p0;

  // ---- stage p1: extended load data, captured on the completing BUSY cycle ----
  logic [31:0] ld_data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_data_p1 <= 32'd0;
    end else if ((state == BUSY) && mem_ready && !req_we_p0) begin
      ld_data_p1 <= load_extend(mem_rdata, req_f3_p0, req_lo_p0);
    end
  end

  // ---- stage W: writeback registers ----
  // While stalled, only RegWriteW changes (to a bubble). The data registers
  // hold their values so the writeback stage sees stable data.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RdW         <= 5'd0;
      PCPlus4W    <= 32'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
    end else if (StallM) begin
      RegWriteW   <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~trap;
      ResultSrcW  <= ResultSrcM;
      RdW         <= RdM;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= ld_data_p1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // The pulse lines up with the bubble that the trapped access writes to W.
  always_ff @(posedge clk) begin
    if (rst) MisalignM <= 1'b0;
    else     MisalignM <= trap;
  end
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// -----------------------------------------------------------------------------
// tb_memory_cycle
//
// Directed and randomized stimulus for memory_cycle. Expected values come from
// a behavioural reference model that applies the byte-lane and extension rules
// directly, and from cycle counts derived from the bus handshake.
// -----------------------------------------------------------------------------
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallM;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignM;
`endif
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_ld = 32'd0;   // last load value the W stage should show

  always #5 clk = ~clk;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM),
`ifdef MISALIGN_TRAP_EN
    .MisalignM(MisalignM),
`endif
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if ((f3 % 4) == 0) return 1;
    if ((f3 % 4) == 1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [2:0] f3,
                                           input logic [31:0] a);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b ^ 32'h80) - 32'h80;
      3'd1:    return (h ^ 32'h8000) - 32'h8000;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz, base;
    logic [3:0] s;
    sz   = size_of(f3);
    base = (int'(a % 4) / sz) * sz;
    for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + sz);
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    logic [31:0] w;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(wd >> (8 * (i % sz)));
    return w;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle();
    RegWriteM = 1'b0; ResultSrcM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
    RdM = 5'd0; PCPlus4M = 32'd0; ALU_ResultM = 32'd0; WriteDataM = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
  endtask

  // Non-memory instruction: one cycle through, no bus activity.
  task automatic alu_op(input logic rw, input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] alu, input string tag);
    RegWriteM = rw; ResultSrcM = 1'b0; MemWriteM = 1'b0;
    Funct3M = 3'($urandom_range(0, 7)); RdM = rd; PCPlus4M = pc;
    ALU_ResultM = alu; WriteDataM = $urandom;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk({tag, "_stall"}, StallM, 0);
    chk({tag, "_req"}, mem_req, 0);
    @(posedge clk); #1;
    chk({tag, "_rw"}, RegWriteW, rw);
    chk({tag, "_rs"}, ResultSrcW, 0);
    chk({tag, "_rd"}, RdW, rd);
    chk({tag, "_pc"}, PCPlus4W, pc);
    chk({tag, "_alu"}, ALU_ResultW, alu);
    chk({tag, "_rdata"}, ReadDataW, exp_ld);
    chk({tag, "_req_after"}, mem_req, 0);
  endtask

  // Memory instruction with mem_ready on the n-th cycle of mem_req.
  task automatic mem_op(input logic rw, input logic rs, input logic mw,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] rdata,
                        input int n, input string tag);
    int stalls, reqs;
    logic done;
    stalls = 0; reqs = 0; done = 1'b0;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3; RdM = rd;
    PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd; mem_ready = 1'b0;
    for (int c = 0; c < n + 8 && !done; c++) begin
      #1;
      if (StallM) stalls++;
      if (c > 0) chk({tag, "_bubble"}, RegWriteW, 0);
      if (mem_req) begin
        reqs++;
        chk({tag, "_addr"}, mem_addr, alu & 32'hFFFF_FFFC);
        chk({tag, "_we"}, mem_we, mw);
        if (mw) begin
          chk({tag, "_wstrb"}, mem_wstrb, ref_strb(f3, alu));
          chk({tag, "_wdata"}, mem_wdata, ref_wdata(f3, wd));
        end
        mem_ready = (reqs == n);
        mem_rdata = (reqs == n) ? rdata : $urandom;
      end else begin
        if (c > 0) done = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    if (rs) exp_ld = ref_load(rdata, f3, alu);
    chk({tag, "_completed"}, done, 1);
    chk({tag, "_stall_cycles"}, stalls, n + 1);
    chk({tag, "_req_cycles"}, reqs, n);
    chk({tag, "_rw"}, RegWriteW, rw);
    chk({tag, "_rs"}, ResultSrcW, rs);
    chk({tag, "_rd"}, RdW, rd);
    chk({tag, "_pc"}, PCPlus4W, pc);
    chk({tag, "_alu"}, ALU_ResultW, alu);
    chk({tag, "_rdata"}, ReadDataW, exp_ld);
  endtask

  initial begin
    logic [2:0]  ld_f3 [5];
    logic [2:0]  st_f3 [3];
    logic [2:0]  f3;
    logic [31:0] a;
    int kind;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};

    // Reset
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw", RegWriteW, 0);
    chk("rst_rs", ResultSrcW, 0);
    chk("rst_rd", RdW, 0);
    chk("rst_pc", PCPlus4W, 0);
    chk("rst_alu", ALU_ResultW, 0);
    chk("rst_rdata", ReadDataW, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_stall", StallM, 0);
    rst = 1'b0;

    // Directed cases
    alu_op(1'b1, 5'd5, 32'h0000_0404, 32'h0000_1234, "alu");
    mem_op(1'b1, 1'b1, 1'b0, 3'd0, 5'd6, 32'h44, 32'h103, 32'h0, 32'h80FF_0000, 4, "lb");
    chk("lb_value", ReadDataW, 32'hFFFF_FF80);
    mem_op(1'b1, 1'b1, 1'b0, 3'd4, 5'd6, 32'h48, 32'h103, 32'h0, 32'h80FF_0000, 4, "lbu");
    chk("lbu_value", ReadDataW, 32'h0000_0080);
    mem_op(1'b0, 1'b0, 1'b1, 3'd1, 5'd0, 32'h4C, 32'h102, 32'hABCD_1234, 32'h0, 2, "sh");
    mem_op(1'b1, 1'b1, 1'b0, 3'd5, 5'd8, 32'h50, 32'h202, 32'h0, 32'h8765_4321, 1, "lhu_n1");
    chk("lhu_value", ReadDataW, 32'h0000_8765);

    // Reset during the second BUSY cycle
    RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
    RdM = 5'd7; PCPlus4M = 32'h54; ALU_ResultM = 32'h200; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_busy1", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid_req", mem_req, 0);
    chk("rstmid_stall", StallM, 0);
    chk("rstmid_rs", ResultSrcW, 0);
    chk("rstmid_pc", PCPlus4W, 0);
    chk("rstmid_alu", ALU_ResultW, 0);
    chk("rstmid_rdata", ReadDataW, 0);
    exp_ld = 32'd0;
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    chk("rstmid_late_req", mem_req, 0);
    chk("rstmid_late_stall", StallM, 0);
    @(posedge clk); #1;
    chk("rstmid_late_rw", RegWriteW, 0);
    chk("rstmid_late_rdata", ReadDataW, 0);

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
    RdM = 5'd9; PCPlus4M = 32'h58; ALU_ResultM = 32'h101; mem_ready = 1'b0;
    #1;
    chk("mis_stall", StallM, 0);
    chk("mis_req", mem_req, 0);
    @(posedge clk); #1;
    chk("mis_pulse", MisalignM, 1);
    chk("mis_rw", RegWriteW, 0);
    chk("mis_req_after", mem_req, 0);
    drive_idle();
    @(posedge clk); #1;
    chk("mis_pulse_end", MisalignM, 0);
`else
    mem_op(1'b1, 1'b1, 1'b0, 3'd2, 5'd9, 32'h58, 32'h101, 32'h0, 32'hCAFE_F00D, 2, "lw_mis");
    chk("lw_mis_value", ReadDataW, 32'hCAFE_F00D);
`endif

    // Randomized mix against the model
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 32'h0000_FFFF);
      if (kind == 0) begin
        alu_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, a, "rnd_alu");
      end else begin
        f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
`ifdef MISALIGN_TRAP_EN
        a = a & ~32'(size_of(f3) - 1);
`endif
        if (kind == 1)
          mem_op(1'b1, 1'b1, 1'b0, f3, 5'($urandom_range(1, 31)), $urandom, a,
                 $urandom, $urandom, $urandom_range(1, 5), "rnd_ld");
        else
          mem_op(1'b0, 1'b0, 1'b1, f3, 5'($urandom_range(0, 31)), $urandom, a,
                 $urandom, $urandom, $urandom_range(1, 5), "rnd_st");
      end
    end

    drive_idle();
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
